curve_knot_loader: RTL

CURVE_KNOT_LOADER -- requirements
Module: curve_knot_loader

---
 rtl/curve_knot_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/curve_knot_loader.sv
// Knot table loader: streams 65 knots into a shadow table, swaps it into the active
// table on a frame boundary. Optional monotonicity check via CURVE_MONO_CHECK_EN.
module curve_knot_loader #(
  parameter int DW_Y  = 9,
  parameter int NKNOT = 65
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [DW_Y-1:0] cfg_data,
  input  logic            cfg_last,
  input  logic            cfg_abort,
  input  logic            frame_start,
  output logic [DW_Y-1:0] y1_0,  y1_1,  y1_2,  y1_3,  y1_4,  y1_5,  y1_6,  y1_7,
  output logic [DW_Y-1:0] y1_8,  y1_9,  y1_10, y1_11, y1_12, y1_13, y1_14, y1_15,
  output logic [DW_Y-1:0] y1_16, y1_17, y1_18, y1_19, y1_20, y1_21, y1_22, y1_23,
  output logic [DW_Y-1:0] y1_24, y1_25, y1_26, y1_27, y1_28, y1_29, y1_30, y1_31,
  output logic [DW_Y-1:0] y1_32, y1_33, y1_34, y1_35, y1_36, y1_37, y1_38, y1_39,
  output logic [DW_Y-1:0] y1_40, y1_41, y1_42, y1_43, y1_44, y1_45, y1_46, y1_47,
  output logic [DW_Y-1:0] y1_48, y1_49, y1_50, y1_51, y1_52, y1_53, y1_54, y1_55,
  output logic [DW_Y-1:0] y1_56, y1_57, y1_58, y1_59, y1_60, y1_61, y1_62, y1_63,
  output logic [DW_Y-1:0] y1_64,
  output logic            commit,
  output logic            err,
  output logic            busy
);

  localparam int IDXW = $clog2(NKNOT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NKNOT - 1);
  localparam logic [DW_Y-1:0] KNOT_MAX = DW_Y'(256);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PEND = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [IDXW-1:0] idx_r, idx_s;
  logic [DW_Y-1:0] shadow_r [NKNOT];
  logic [DW_Y-1:0] active_r [NKNOT];
  logic [DW_Y-1:0] clamp_s;
  logic            xfer_s, wr_en_s, copy_s, commit_s, err_s, mono_bad_s;

  function automatic logic [DW_Y-1:0] clamp_knot(input logic [DW_Y-1:0] v);
    return (v > KNOT_MAX) ? KNOT_MAX : v;
  endfunction

  assign clamp_s = clamp_knot(cfg_data);
  assign xfer_s  = cfg_valid && cfg_ready;

`ifdef CURVE_MONO_CHECK_EN
  logic [DW_Y-1:0] prev_r;

  // Last accepted clamped knot, reference for the non-decreasing check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_r <= '0;
    else if (wr_en_s) prev_r <= clamp_s;
  end

  assign mono_bad_s = (clamp_s < prev_r);
`else
  assign mono_bad_s = 1'b0;
`endif

  // Next-state: abort beats transfer and frame_start; a misplaced last marker rejects the load.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    wr_en_s  = 1'b0;
    copy_s   = 1'b0;
    commit_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s && cfg_last) begin
          err_s = 1'b1;
        end else if (xfer_s) begin
          wr_en_s = 1'b1;
          idx_s   = IDXW'(1);
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_s = IDLE;
          idx_s   = '0;
        end else if (xfer_s) begin
          if ((cfg_last != (idx_r == LAST_IDX)) || mono_bad_s) begin
            err_s   = 1'b1;
            state_s = IDLE;
            idx_s   = '0;
          end else if (cfg_last) begin
            wr_en_s = 1'b1;
            state_s = PEND;
          end else begin
            wr_en_s = 1'b1;
            idx_s   = idx_r + IDXW'(1);
          end
        end else begin
          state_s = LOAD;
        end
      end
      PEND: begin
        if (cfg_abort) begin
          state_s = IDLE;
          idx_s   = '0;
        end else if (frame_start) begin
          copy_s   = 1'b1;
          commit_s = 1'b1;
          state_s  = IDLE;
          idx_s    = '0;
        end else begin
          state_s = PEND;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      commit    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      commit    <= commit_s;
      err       <= err_s;
      busy      <= (state_s != IDLE);
      cfg_ready <= (state_s != PEND);
    end
  end

  // Shadow table: filled one knot per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NKNOT; k++) shadow_r[k] <= '0;
    end else if (wr_en_s) begin
      shadow_r[idx_r] <= clamp_s;
    end
  end

  // Active table: identity ramp out of reset, replaced whole on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NKNOT; k++) active_r[k] <= DW_Y'(4 * k);
    end else if (copy_s) begin
      for (int k = 0; k < NKNOT; k++) active_r[k] <= shadow_r[k];
    end
  end

  assign y1_0  = active_r[0];  assign y1_1  = active_r[1];  assign y1_2  = active_r[2];  assign y1_3  = active_r[3];
  assign y1_4  = active_r[4];  assign y1_5  = active_r[5];  assign y1_6  = active_r[6];  assign y1_7  = active_r[7];
  assign y1_8  = active_r[8];  assign y1_9  = active_r[9];  assign y1_10 = active_r[10]; assign y1_11 = active_r[11];
  assign y1_12 = active_r[12]; assign y1_13 = active_r[13]; assign y1_14 = active_r[14]; assign y1_15 = active_r[15];
  assign y1_16 = active_r[16]; assign y1_17 = active_r[17]; assign y1_18 = active_r[18]; assign y1_19 = active_r[19];
  assign y1_20 = active_r[20]; assign y1_21 = active_r[21]; assign y1_22 = active_r[22]; assign y1_23 = active_r[23];
  assign y1_24 = active_r[24]; assign y1_25 = active_r[25]; assign y1_26 = active_r[26]; assign y1_27 = active_r[27];
  assign y1_28 = active_r[28]; assign y1_29 = active_r[29]; assign y1_30 = active_r[30]; assign y1_31 = active_r[31];
  assign y1_32 = active_r[32]; assign y1_33 = active_r[33]; assign y1_34 = active_r[34]; assign y1_35 = active_r[35];
  assign y1_36 = active_r[36]; assign y1_37 = active_r[37]; assign y1_38 = active_r[38]; assign y1_39 = active_r[39];
  assign y1_40 = active_r[40]; assign y1_41 = active_r[41]; assign y1_42 = active_r[42]; assign y1_43 = active_r[43];
  assign y1_44 = active_r[44]; assign y1_45 = active_r[45]; assign y1_46 = active_r[46]; assign y1_47 = active_r[47];
  assign y1_48 = active_r[48]; assign y1_49 = active_r[49]; assign y1_50 = active_r[50]; assign y1_51 = active_r[51];
  assign y1_52 = active_r[52]; assign y1_53 = active_r[53]; assign y1_54 = active_r[54]; assign y1_55 = active_r[55];
  assign y1_56 = active_r[56]; assign y1_57 = active_r[57]; assign y1_58 = active_r[58]; assign y1_59 = active_r[59];
  assign y1_60 = active_r[60]; assign y1_61 = active_r[61]; assign y1_62 = active_r[62]; assign y1_63 = active_r[63];
  assign y1_64 = active_r[64];

endmodule
